// File: rtl/skinscore_packer.sv
// Skin-score byte packer: gathers 8-bit scores into 32-bit words (oldest byte
// in [7:0]) and queues them in a first-word-fall-through FIFO with
// almost-full throttling and a sticky overflow flag.
module skinscore_packer #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  score_in,
    input  logic        score_in_valid,
    input  logic        flush,
    output logic [31:0] word_out,
    output logic [2:0]  word_out_bytes,
    output logic        word_out_valid,
    input  logic        word_out_ready,
    output logic        almost_full,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AfullC = CW'(AFULL_THRESH);

    // Pack stage: only three lanes need storage, the fourth byte is taken live.
    logic [23:0]   pack_q, pack_d;
    logic [1:0]    pcnt_q, pcnt_d;
    logic [31:0]   new_word;
    logic [2:0]    new_bytes;
    logic          push;

    // FIFO state
    logic [34:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          full, empty, pop, wr_en;
    logic [34:0]   head;

    // Assemble the outgoing word and decide when to close it.
    always_comb begin
        pack_d   = pack_q;
        pcnt_d   = pcnt_q;
        new_word = '0;
        // Stale lanes at or above pcnt are masked so partial words carry zeros.
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < pcnt_q) begin
                new_word[8*i +: 8] = pack_q[8*i +: 8];
            end
        end
        if (score_in_valid) begin
            new_word[{pcnt_q, 3'b000} +: 8] = score_in;
        end
        new_bytes = {1'b0, pcnt_q} + {2'b00, score_in_valid};
        push = (score_in_valid && (pcnt_q == 2'd3)) ||
               (flush && (score_in_valid || (pcnt_q != 2'd0)));
        if (push) begin
            pcnt_d = 2'd0;
        end else if (score_in_valid) begin
            pcnt_d = pcnt_q + 2'd1;
            pack_d[{pcnt_q, 3'b000} +: 8] = score_in;
        end
    end

    // FIFO control: a push while full is only accepted if the head pops.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DepthC);
        pop      = !empty && word_out_ready;
        wr_en    = push && (!full || pop);
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
        afull_d = (count_d >= AfullC);
        ovf_d   = ovf_q || (push && full && !pop);
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack_q   <= '0;
            pcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            pack_q   <= pack_d;
            pcnt_q   <= pcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {new_bytes, new_word};
        end
    end

    // Fall-through head, forced to zero when empty.
    always_comb begin
        head           = mem_q[rd_ptr_q];
        word_out_valid = !empty;
        word_out       = empty ? 32'h0 : head[31:0];
        word_out_bytes = empty ? 3'd0 : head[34:32];
        almost_full    = afull_q;
        overflow       = ovf_q;
    end

endmodule

// File: tb/tb_skinscore_packer.sv
// Bench for skinscore_packer: directed scenarios plus random traffic, checked
// every cycle against a byte-queue / word-queue reference model.
module tb_skinscore_packer;

    localparam int Depth = 8;
    localparam int Afull = 6;

    typedef struct packed {
        logic [31:0] w;
        logic [2:0]  b;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  score_in;
    logic        score_in_valid;
    logic        flush;
    logic [31:0] word_out;
    logic [2:0]  word_out_bytes;
    logic        word_out_valid;
    logic        word_out_ready;
    logic        almost_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] pb[$];
    ent_t       q[$];
    logic       exp_af  = 1'b0;
    logic       exp_ovf = 1'b0;

    skinscore_packer #(
        .FIFO_DEPTH  (Depth),
        .AFULL_THRESH(Afull)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .score_in      (score_in),
        .score_in_valid(score_in_valid),
        .flush         (flush),
        .word_out      (word_out),
        .word_out_bytes(word_out_bytes),
        .word_out_valid(word_out_valid),
        .word_out_ready(word_out_ready),
        .almost_full   (almost_full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_outputs(input string tag);
        logic [31:0] ew;
        logic [2:0]  eb;
        logic        ev;
        ev = (q.size() > 0);
        ew = ev ? q[0].w : 32'h0;
        eb = ev ? q[0].b : 3'd0;
        checks++;
        assert (word_out_valid === ev) else begin
            errors++;
            $error("FAIL %s valid: got %b expected %b", tag, word_out_valid, ev);
        end
        checks++;
        assert (word_out === ew) else begin
            errors++;
            $error("FAIL %s word: got %h expected %h", tag, word_out, ew);
        end
        checks++;
        assert (word_out_bytes === eb) else begin
            errors++;
            $error("FAIL %s bytes: got %0d expected %0d", tag, word_out_bytes, eb);
        end
        checks++;
        assert (almost_full === exp_af) else begin
            errors++;
            $error("FAIL %s almost_full: got %b expected %b", tag, almost_full, exp_af);
        end
        checks++;
        assert (overflow === exp_ovf) else begin
            errors++;
            $error("FAIL %s overflow: got %b expected %b", tag, overflow, exp_ovf);
        end
    endtask

    // One clock of behaviour: bytes accumulate, a word closes at 4 bytes or on
    // flush, the consumer takes the head, and a word finding no room is lost.
    task automatic model_step(input logic v, input logic [7:0] s, input logic f,
                              input logic r);
        logic        do_pop;
        logic        have_word;
        ent_t        e;
        do_pop = (q.size() > 0) && r;
        if (v) pb.push_back(s);
        have_word = (pb.size() == 4) || (f && pb.size() > 0);
        e = '0;
        if (have_word) begin
            for (int i = 0; i < pb.size(); i++) e.w[8*i +: 8] = pb[i];
            e.b = 3'(pb.size());
            pb.delete();
        end
        if (do_pop) void'(q.pop_front());
        if (have_word) begin
            if (q.size() < Depth) q.push_back(e);
            else exp_ovf = 1'b1;
        end
        exp_af = (q.size() >= Afull);
    endtask

    task automatic cycle(input string tag, input logic v, input logic [7:0] s,
                         input logic f, input logic r);
        score_in_valid = v;
        score_in       = s;
        flush          = f;
        word_out_ready = r;
        check_outputs(tag);
        model_step(v, s, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        pb.delete();
        q.delete();
        exp_af  = 1'b0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        score_in       = 8'h0;
        score_in_valid = 1'b0;
        flush          = 1'b0;
        word_out_ready = 1'b0;
        #12;
        check_outputs("reset");
        rst = 1'b1;

        // Four scores, one full word, one cycle latency, single-cycle valid
        cycle("s31", 1'b1, 8'h11, 1'b0, 1'b1);
        cycle("s31", 1'b1, 8'h22, 1'b0, 1'b1);
        cycle("s31", 1'b1, 8'h33, 1'b0, 1'b1);
        cycle("s31", 1'b1, 8'h44, 1'b0, 1'b1);
        cycle("s31_out", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("s31_gone", 1'b0, 8'h00, 1'b0, 1'b1);

        // Partial word by lone flush; a second lone flush does nothing
        cycle("s32", 1'b1, 8'hA0, 1'b0, 1'b1);
        cycle("s32", 1'b1, 8'hB0, 1'b0, 1'b1);
        cycle("s32_fl", 1'b0, 8'h00, 1'b1, 1'b1);
        cycle("s32_fl2", 1'b0, 8'h00, 1'b1, 1'b1);
        cycle("s32_idle", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("s32_idle", 1'b0, 8'h00, 1'b0, 1'b1);

        // Flush together with a score, then pcnt restarts at 0
        cycle("s33", 1'b1, 8'h01, 1'b0, 1'b1);
        cycle("s33", 1'b1, 8'h02, 1'b0, 1'b1);
        cycle("s33_fl", 1'b1, 8'h03, 1'b1, 1'b1);
        cycle("s33_out", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle("s33_new", 1'b1, 8'(8'h50 + i), 1'b0, 1'b1);
        cycle("s33_new_out", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("s33_idle", 1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to full, then a word completes while ready: push and pop together
        for (int i = 0; i < 32; i++) cycle("s35_fill", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("s35", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle("s35_both", 1'b1, 8'hC3, 1'b0, 1'b1);
        cycle("s35_after", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("s35_after", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("s35_drain", 1'b0, 8'h00, 1'b0, 1'b1);

        // 36 scores with no consumer: almost_full, full, ninth word dropped
        for (int i = 0; i < 36; i++) cycle("s34_fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle("s34_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("s34_drain", 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset with 3 words queued and two bytes packed
        for (int i = 0; i < 14; i++) cycle("s36_fill", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        score_in_valid = 1'b0;
        flush          = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("s36_async");
        @(posedge clk);
        #1;
        check_outputs("s36_held");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle("s36_new", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        cycle("s36_one", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("s36_one", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("s36_empty", 1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic with bursty backpressure
        for (int i = 0; i < 400; i++) begin
            logic v, f, r;
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 9) == 0);
            r = (i % 80 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            cycle("rand", v, 8'($urandom), f, r);
        end
        for (int i = 0; i < 12; i++) cycle("rand_drain", 1'b0, 8'h00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skinscore_packer.md
SKINSCORE_PACKER -- requirements
Module: skinscore_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving the number of 32-bit word entries (power of two, minimum 4).
REQ-002 SHALL have parameter AFULL_THRESH, default 6, giving the occupancy at or above which almost_full asserts (1..FIFO_DEPTH).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have score_in  input  8  skin score from the datapath output stage.
REQ-007 SHALL have score_in_valid  input  1  score_in qualifier; there is no backpressure on this side.
REQ-008 SHALL have flush  input  1  single-cycle pulse that closes the current partial word (end of frame or line).
REQ-009 SHALL have word_out  output  32  packed scores; byte 0 in [7:0] is the oldest.
REQ-010 SHALL have word_out_bytes  output  3  number of valid bytes in word_out (1..4).
REQ-011 SHALL have word_out_valid  output  1  FIFO head is valid.
REQ-012 SHALL have word_out_ready  input  1  consumer accepts the head word.
REQ-013 SHALL have almost_full  output  1  throttle request to the pixel source.
REQ-014 SHALL have overflow  output  1  sticky flag set when a word is lost.

Function
REQ-015 SHALL keep a pack register with byte counter pcnt (0..3); each cycle with score_in_valid=1, it SHALL write score_in into byte lane pcnt and increment pcnt.
REQ-016 SHALL push {4 bytes, bytes=4} into the FIFO in the cycle the fourth score arrives, and SHALL reset pcnt to 0.
REQ-017 On flush with pcnt>0 and no valid score, SHALL push the partial word with unused upper lanes zeroed and bytes=pcnt, then set pcnt=0.
REQ-018 On flush coinciding with a valid score, SHALL include that score first, then push the word with bytes=pcnt+1 (4 if the score completes the word), then set pcnt=0.
REQ-019 On flush with pcnt=0 and no valid score, SHALL take no action.
REQ-020 SHALL implement the FIFO as first-word-fall-through: word_out_valid=1 whenever occupancy>0, with word_out/word_out_bytes showing the head entry.
REQ-021 SHALL drive word_out=0 and word_out_bytes=0 when the FIFO is empty.
REQ-022 SHALL pop on a cycle with word_out_valid && word_out_ready; the head SHALL remain stable while valid && !ready.
REQ-023 Latency: a word completed in cycle N SHALL appear at word_out with word_out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-024 On simultaneous push and pop, occupancy SHALL be unchanged; this also applies when the FIFO is full, in which case the push SHALL be accepted.
REQ-025 On a push when full without a pop, SHALL drop the new word, keep FIFO contents unchanged, and set overflow=1 until reset.
REQ-026 SHALL use read and write pointers that wrap modulo FIFO_DEPTH, with occupancy held in a (log2(FIFO_DEPTH)+1)-bit counter.
REQ-027 SHALL drive almost_full as a registered output equal to (next occupancy >= AFULL_THRESH).

Reset
REQ-028 While rst=0, SHALL clear pcnt, pack register, pointers, occupancy, almost_full and overflow to 0, so that word_out_valid=0, word_out=0 and word_out_bytes=0.
REQ-029 Reset asserted mid-operation SHALL discard any partial word and all FIFO contents.
REQ-030 The first score accepted SHALL be the one presented in the first rising edge after rst deasserts.

Verification
REQ-031 Scores 0x11,0x22,0x33,0x44 on consecutive cycles, ready=1 -> one cycle later word_out=0x44332211, bytes=4, valid high for one cycle.
REQ-032 Scores 0xA0,0xB0, then flush alone -> word_out=0x0000B0A0, bytes=2; a second flush alone -> no push.
REQ-033 Scores 0x01,0x02,0x03 with flush on the cycle of 0x03 -> word_out=0x00030201, bytes=3, pcnt=0 afterwards.
REQ-034 ready=0 with 36 scores pushed at defaults -> almost_full=1 once occupancy reaches 6, FIFO full at 8 words, ninth word dropped, overflow=1; draining then yields the first 8 words in order.
REQ-035 FIFO full, a word completes while ready=1 -> push and pop both happen, occupancy stays 8, overflow stays 0.
REQ-036 rst=0 asserted asynchronously with 3 words queued and pcnt=2 -> all outputs 0 immediately; after release, 4 new scores produce exactly one word.
